// File: rtl/boot_sequencer.sv
// boot_sequencer
//
// Sequences the 9-bit processor through program load and release. While a
// host streams program words in, the processor is held in reset and the
// shared memory port is driven from the load path. After the last word the
// processor stays in reset for HOLD_CYCLES more cycles, is then released,
// and the memory port is handed over to the processor.
//
// Ports:
//   Clock, Resetn        system clock (rising edge), async active-low reset
//   start, load_len      begin a (re)load of load_len words (0 = none)
//   host_data/valid/ready  host word stream, accepted on valid & ready
//   halt                 suppresses proc_Run while running
//   proc_ADDR/DOUT/Write processor memory request, forwarded only in RUN
//   mem_ADDR/DOUT/Write  shared memory port
//   proc_Resetn          registered active-low processor reset
//   proc_Run             processor Run (= ~halt in RUN)
//   busy                 loading or holding
//   done                 one-cycle pulse on the first RUN cycle

module boot_sequencer #(
    parameter int DW          = 9,
    parameter int AW          = 9,
    parameter int START_ADDR  = 0,
    parameter int HOLD_CYCLES = 2
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic [AW-1:0] load_len,
    input  logic [DW-1:0] host_data,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          halt,
    input  logic [AW-1:0] proc_ADDR,
    input  logic [DW-1:0] proc_DOUT,
    input  logic          proc_Write,
    output logic [AW-1:0] mem_ADDR,
    output logic [DW-1:0] mem_DOUT,
    output logic          mem_Write,
    output logic          proc_Resetn,
    output logic          proc_Run,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    localparam logic [AW-1:0] START_A   = AW'(START_ADDR);
    localparam logic [3:0]    HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    // One bit wider than the address so a length of 2^AW-1 counts cleanly.
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    hold_cnt_q, hold_cnt_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          ld_write_q, ld_write_d;
    logic          proc_resetn_q, proc_resetn_d;
    logic          done_q, done_d;
    logic          beat;

    assign host_ready = (state_q == S_LOAD) && (cnt_q < len_q);
    assign beat       = host_valid & host_ready;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            hold_cnt_q    <= '0;
            ld_addr_q     <= '0;
            ld_data_q     <= '0;
            ld_write_q    <= 1'b0;
            proc_resetn_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            hold_cnt_q    <= hold_cnt_d;
            ld_addr_q     <= ld_addr_d;
            ld_data_q     <= ld_data_d;
            ld_write_q    <= ld_write_d;
            proc_resetn_q <= proc_resetn_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hold_cnt_d = hold_cnt_q;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
        ld_write_d = 1'b0;

        case (state_q)
            S_LOAD: begin
                // Words are registered, so each write lands one cycle after
                // its acceptance; the last one lands in the first HOLD cycle.
                if (beat) begin
                    ld_addr_d  = START_A + cnt_q[AW-1:0];
                    ld_data_d  = host_data;
                    ld_write_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
            end
        endcase

        // A restart from IDLE, HOLD or RUN aborts whatever is going on; an
        // empty image goes straight to the reset-hold phase.
        if (start && (state_q != S_LOAD)) begin
            len_d      = {1'b0, load_len};
            cnt_d      = '0;
            hold_cnt_d = '0;
            state_d    = (load_len == '0) ? S_HOLD : S_LOAD;
        end
    end

    // proc_Resetn and done come from flops so the processor sees a clean
    // release exactly on the first RUN cycle.
    always_comb begin
        proc_resetn_d = (state_d == S_RUN);
        done_d        = (state_d == S_RUN) && (state_q != S_RUN);
    end

    // Memory port mux: the processor owns it only while running.
    always_comb begin
        if (state_q == S_RUN) begin
            mem_ADDR  = proc_ADDR;
            mem_DOUT  = proc_DOUT;
            mem_Write = proc_Write;
        end else begin
            mem_ADDR  = ld_addr_q;
            mem_DOUT  = ld_data_q;
            mem_Write = ld_write_q;
        end
    end

    assign proc_Resetn = proc_resetn_q;
    assign proc_Run    = (state_q == S_RUN) & ~halt;
    assign busy        = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign done        = done_q;

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

    localparam int DW      = 9;
    localparam int AW      = 9;
    localparam int HC      = 2;
    localparam int START_W = 510;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          start;
    logic [AW-1:0] load_len;
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          halt;
    logic [AW-1:0] proc_ADDR;
    logic [DW-1:0] proc_DOUT;
    logic          proc_Write;

    logic          host_ready, mem_Write, proc_Resetn, proc_Run, busy, done;
    logic [AW-1:0] mem_ADDR;
    logic [DW-1:0] mem_DOUT;

    logic          host_ready_w, mem_Write_w, proc_Resetn_w, proc_Run_w, busy_w, done_w;
    logic [AW-1:0] mem_ADDR_w;
    logic [DW-1:0] mem_DOUT_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] data_tbl [3];
    bit            use_tbl = 1'b0;

    boot_sequencer #(.DW(DW), .AW(AW), .START_ADDR(0), .HOLD_CYCLES(HC)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .load_len(load_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .halt(halt), .proc_ADDR(proc_ADDR), .proc_DOUT(proc_DOUT), .proc_Write(proc_Write),
        .mem_ADDR(mem_ADDR), .mem_DOUT(mem_DOUT), .mem_Write(mem_Write),
        .proc_Resetn(proc_Resetn), .proc_Run(proc_Run), .busy(busy), .done(done)
    );

    boot_sequencer #(.DW(DW), .AW(AW), .START_ADDR(START_W), .HOLD_CYCLES(HC)) dut_w (
        .Clock(Clock), .Resetn(Resetn), .start(start), .load_len(load_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready_w),
        .halt(halt), .proc_ADDR(proc_ADDR), .proc_DOUT(proc_DOUT), .proc_Write(proc_Write),
        .mem_ADDR(mem_ADDR_w), .mem_DOUT(mem_DOUT_w), .mem_Write(mem_Write_w),
        .proc_Resetn(proc_Resetn_w), .proc_Run(proc_Run_w), .busy(busy_w), .done(done_w)
    );

    always #5 Clock = ~Clock;

    task tick;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task test_reset;
        Resetn     = 1'b0;
        start      = 1'b0;
        load_len   = '0;
        host_data  = '0;
        host_valid = 1'b0;
        halt       = 1'b0;
        proc_ADDR  = 9'h0C3;
        proc_DOUT  = 9'h155;
        proc_Write = 1'b1;
        @(negedge Clock);
        n_checks++;
        if ({host_ready, busy, proc_Resetn, proc_Run, done, mem_Write} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {host_ready, busy, proc_Resetn, proc_Run, done, mem_Write});
        end
        n_checks++;
        if ({mem_ADDR, mem_DOUT, mem_ADDR_w} !== 27'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem: got %h/%h/%h expected 0/0/0", mem_ADDR, mem_DOUT, mem_ADDR_w);
        end
        Resetn = 1'b1;
        tick();
        n_checks++;
        if ({host_ready, busy, proc_Resetn, mem_Write, mem_ADDR} !== 13'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %b/%h expected 0000/000",
                     {host_ready, busy, proc_Resetn, mem_Write}, mem_ADDR);
        end
    endtask

    task test_reset_mid_load;
        start    = 1'b1;
        load_len = 9'd5;
        tick();
        start      = 1'b0;
        host_valid = 1'b1;
        host_data  = 9'h0AA;
        tick();
        host_data = 9'h055;
        tick();
        host_valid = 1'b0;
        n_checks++;
        if ({mem_Write, mem_ADDR, mem_DOUT} !== {1'b1, 9'd1, 9'h055}) begin
            n_fail++;
            $display("[TB] FAIL second_write: got %b/%h/%h expected 1/001/055", mem_Write, mem_ADDR, mem_DOUT);
        end
        #2;
        Resetn = 1'b0;
        #1;
        n_checks++;
        if ({host_ready, busy, proc_Resetn, proc_Run, done, mem_Write, mem_ADDR, mem_DOUT, mem_ADDR_w} !== 33'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b %h %h %h expected all zero",
                     {host_ready, busy, proc_Resetn, proc_Run, done, mem_Write}, mem_ADDR, mem_DOUT, mem_ADDR_w);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            proc_ADDR  = 9'($urandom_range(1, 511));
            proc_DOUT  = 9'($urandom_range(1, 511));
            proc_Write = 1'b1;
            #1;
            n_checks++;
            if ({host_ready, busy, proc_Resetn, mem_Write, mem_ADDR, mem_DOUT} !== 22'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_no_forward: got %b %h %h expected 0000 000 000",
                         {host_ready, busy, proc_Resetn, mem_Write}, mem_ADDR, mem_DOUT);
            end
            tick();
        end
    endtask

    // mode 0: host_valid always 1; mode 1: toggles 1,0,1,...; mode 2: random
    // with random start/halt noise that must be ignored during the load.
    task load_and_boot(input int len, input int mode);
        int            acc, guard, step;
        bit            pend, v;
        logic [AW-1:0] exp_a, exp_aw;
        logic [DW-1:0] exp_d;
        start      = 1'b1;
        load_len   = AW'(len);
        host_valid = 1'b0;
        tick();
        start = 1'b0;
        acc   = 0;
        guard = 0;
        step  = 0;
        pend  = 1'b0;
        exp_a  = '0;
        exp_aw = '0;
        exp_d  = '0;
        while (acc < len && guard < 2000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (step % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            host_valid = v;
            host_data  = use_tbl ? data_tbl[acc] : 9'($urandom);
            halt       = 1'($urandom);
            proc_Write = 1'($urandom);
            proc_ADDR  = 9'($urandom);
            proc_DOUT  = 9'($urandom);
            if (mode == 2) begin
                start    = ($urandom_range(0, 3) == 0);
                load_len = 9'($urandom);
            end
            #1;
            n_checks++;
            if ({host_ready, busy, proc_Resetn, proc_Run, done} !== 5'b11000) begin
                n_fail++;
                $display("[TB] FAIL load_ctrl word %0d: got %b expected 11000", acc,
                         {host_ready, busy, proc_Resetn, proc_Run, done});
            end
            n_checks++;
            if ({mem_Write, mem_Write_w} !== {pend, pend}) begin
                n_fail++;
                $display("[TB] FAIL load_write_strobe word %0d: got %b%b expected %b", acc, mem_Write, mem_Write_w, pend);
            end
            if (pend) begin
                n_checks++;
                if ({mem_ADDR, mem_DOUT, mem_ADDR_w} !== {exp_a, exp_d, exp_aw}) begin
                    n_fail++;
                    $display("[TB] FAIL load_write_data: got %h/%h/%h expected %h/%h/%h",
                             mem_ADDR, mem_DOUT, mem_ADDR_w, exp_a, exp_d, exp_aw);
                end
            end
            if (v) begin
                pend   = 1'b1;
                exp_a  = AW'(acc % 512);
                exp_aw = AW'((START_W + acc) % 512);
                exp_d  = host_data;
                acc++;
            end else begin
                pend = 1'b0;
            end
            step++;
            guard++;
            tick();
        end
        if (guard >= 2000) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL load_timeout: got %0d words expected %0d", acc, len);
        end
        start      = 1'b0;
        host_valid = 1'($urandom);
        for (int h = 0; h < HC; h++) begin
            #1;
            n_checks++;
            if ({host_ready, busy, proc_Resetn, proc_Run, done} !== 5'b01000) begin
                n_fail++;
                $display("[TB] FAIL hold_ctrl cycle %0d: got %b expected 01000", h,
                         {host_ready, busy, proc_Resetn, proc_Run, done});
            end
            n_checks++;
            if ({mem_Write, mem_Write_w} !== {2{(h == 0) && pend}}) begin
                n_fail++;
                $display("[TB] FAIL hold_write cycle %0d: got %b%b expected %b", h, mem_Write, mem_Write_w,
                         (h == 0) && pend);
            end
            if (h == 0 && pend) begin
                n_checks++;
                if ({mem_ADDR, mem_DOUT, mem_ADDR_w} !== {exp_a, exp_d, exp_aw}) begin
                    n_fail++;
                    $display("[TB] FAIL final_write: got %h/%h/%h expected %h/%h/%h",
                             mem_ADDR, mem_DOUT, mem_ADDR_w, exp_a, exp_d, exp_aw);
                end
            end
            tick();
        end
        halt = 1'b0;
        #1;
        n_checks++;
        if ({host_ready, busy, proc_Resetn, proc_Run, done} !== 5'b00111) begin
            n_fail++;
            $display("[TB] FAIL run_entry: got %b expected 00111", {host_ready, busy, proc_Resetn, proc_Run, done});
        end
        tick();
        n_checks++;
        if ({proc_Resetn, done} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL done_single_pulse: got %b expected 10", {proc_Resetn, done});
        end
    endtask

    task test_basic_load;
        data_tbl[0] = 9'h041;
        data_tbl[1] = 9'h0A2;
        data_tbl[2] = 9'h1FF;
        use_tbl = 1'b1;
        load_and_boot(3, 0);
        use_tbl = 1'b0;
    endtask

    task test_toggle_valid;
        load_and_boot(3, 1);
    endtask

    task test_empty_load;
        load_and_boot(0, 0);
    endtask

    task test_passthrough;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w, hl;
        for (int i = 0; i < 8; i++) begin
            a  = (i == 0) ? 9'h0C3 : 9'($urandom);
            d  = (i == 0) ? 9'h155 : 9'($urandom);
            w  = (i == 0) ? 1'b1 : 1'($urandom);
            hl = (i == 1) ? 1'b1 : 1'($urandom);
            proc_ADDR  = a;
            proc_DOUT  = d;
            proc_Write = w;
            halt       = hl;
            #1;
            n_checks++;
            if ({mem_ADDR, mem_DOUT, mem_Write, mem_ADDR_w, mem_Write_w} !== {a, d, w, a, w}) begin
                n_fail++;
                $display("[TB] FAIL passthrough: got %h/%h/%b expected %h/%h/%b", mem_ADDR, mem_DOUT, mem_Write, a, d, w);
            end
            n_checks++;
            if ({proc_Resetn, proc_Run, busy, done} !== {1'b1, ~hl, 2'b00}) begin
                n_fail++;
                $display("[TB] FAIL run_halt: got %b expected %b", {proc_Resetn, proc_Run, busy, done},
                         {1'b1, ~hl, 2'b00});
            end
            tick();
        end
        halt = 1'b0;
    endtask

    task test_restart_from_run;
        proc_Write = 1'b1;
        load_and_boot(4, 0);
    endtask

    task test_restart_in_hold;
        start    = 1'b1;
        load_len = '0;
        tick();
        start = 1'b0;
        #1;
        n_checks++;
        if ({host_ready, busy, proc_Resetn} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL empty_hold: got %b expected 010", {host_ready, busy, proc_Resetn});
        end
        load_and_boot(2, 2);
    endtask

    task test_random;
        for (int i = 0; i < 6; i++) begin
            load_and_boot($urandom_range(1, 8), 2);
        end
        test_passthrough();
    endtask

    initial begin
        $display("[TB] boot_sequencer test start");
        test_reset();
        test_reset_mid_load();
        test_basic_load();
        test_toggle_valid();
        test_passthrough();
        test_empty_load();
        test_restart_from_run();
        test_restart_in_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
